td4_run_ctrl: RTL and testbench
===============================

# td4_run_ctrl

Run controller for the TD4 4-bit CPU. Owns the CPU's 16x8 program memory and accepts a 16-byte program over a valid/ready byte stream while holding the CPU in reset. It then releases the CPU for a bounded (or unbounded) number of cycles and freezes the final LED value when it halts. It sits between the board I/O (loader, buttons) and the CPU's `n_reset`, `addr`, `data` and `led` pins.

## Interface
- `LIMIT_W`, default 16: width of the run-cycle budget and its counter.
- `clk`  in  1  system clock, shared with the CPU.
- `n_reset`  in  1  synchronous, active-low reset.
- `load_start`  in  1  pulse: begin loading a new program.
- `run_start`  in  1  pulse: start running the program.
- `halt_req`  in  1  pulse: stop a running program.
- `run_limit`  in  LIMIT_W  cycle budget, sampled on an accepted `run_start`; 0 = unlimited.
- `wr_valid`  in  1  program byte valid.
- `wr_data`  in  8  program byte.
- `wr_ready`  out  1  byte accepted on a cycle where `wr_valid` and `wr_ready` are both high.
- `cpu_n_reset`  out  1  drives the CPU `n_reset` pin.
- `cpu_addr`  in  4  CPU instruction address.
- `cpu_data`  out  8  instruction at `cpu_addr`.
- `cpu_led`  in  4  CPU LED output.
- `led`  out  4  board LEDs.
- `busy`  out  1  high in LOAD or RUN.
- `done`  out  1  high in HALT.

## Operation
- **States:** IDLE, LOAD, RUN, HALT.
- **Reset:**
  - state = IDLE, write pointer = 0, counter = 0.
  - All 16 program words = 0x00.
  - Outputs: `led` = 0, `wr_ready` = 0, `cpu_n_reset` = 0, `busy` = 0, `done` = 0.
- **Command priority** (per cycle): `load_start` > `halt_req` > `run_start`.
- **IDLE / HALT:**
  - `load_start` → LOAD.
  - `run_start` → RUN; latches `run_limit` and clears the counter.
  - `halt_req` is ignored.
- **LOAD:**
  - `wr_ready` = 1. Each accepted byte is written to `mem[wptr]`, then `wptr` increments.
  - Acceptance of the 16th byte (`wptr` = 15) → IDLE, `wptr` = 0.
  - `load_start` in LOAD restarts at `wptr` = 0. Bytes already written stay until overwritten.
  - `run_start` and `halt_req` are ignored.
- **RUN:**
  - `cpu_n_reset` = 1. The counter increments every cycle.
  - Limit L ≠ 0: when the counter equals L−1 → HALT. The CPU therefore sees exactly L rising edges with `n_reset` high, i.e. it executes L instructions.
  - L = 0: runs until `halt_req` (→ HALT) or `load_start` (→ LOAD, aborts the run).
  - The counter saturates at all-ones in unlimited mode; no wrap.
  - `run_start` in RUN is ignored.
- **`cpu_n_reset`:** equals (state == RUN), decoded directly from the state register.
- **`cpu_data`:** combinational `mem[cpu_addr]`.
  - In LOAD the CPU is in reset, so write/read collisions are irrelevant.
  - A write takes effect on the edge it is accepted.
- **`led`:**
  - Register; loads `cpu_led` on every edge where the previous-cycle state was RUN, otherwise holds.
  - It therefore captures the CPU output after the final instruction, one cycle after HALT entry.
  - Cleared to 0 on entry to LOAD.
- **`busy` / `done`:** pure state decode.

## Timing
- `load_start` at edge k → `wr_ready` high from cycle k+1.
- Final byte accepted at edge k → IDLE at k+1.
- `run_start` at edge k → `cpu_n_reset` high during cycles k+1 … k+L. It falls in cycle k+L+1, when `done` rises.
- `led` equals the final `cpu_led` from cycle k+L+2.
- The CPU's own reset is synchronous: after `cpu_n_reset` falls, the CPU registers clear on the following edge.
- `halt_req` at edge k → `cpu_n_reset` low in cycle k+1.
- Same-cycle `halt_req` and a limit expiry give the same HALT; no double effect.
- `n_reset` low overrides everything at the next edge, including mid-load and mid-run. Program memory is cleared.

## Structure
- **Package `td4_pkg`:**
  - `run_state_t` enum (IDLE, LOAD, RUN, HALT).
  - `PROG_DEPTH` = 16, `INSN_W` = 8, `ADDR_W` = 4.
  - TD4 opcode constants, shared with the CPU and testbench.
- **Sub-module `td4_prog_mem`:** 16x8 register file with synchronous write, asynchronous read, and synchronous clear on reset.
- **Controller:** the FSM, write pointer, cycle counter and LED capture register.

## Test plan
- **Reset values:** assert reset, then release → `cpu_n_reset` = 0, `led` = 0, `done` = 0, `busy` = 0, `cpu_data` = 0x00 for all addresses.
- **Load with stalls:** load 16 bytes {0xB5, 0xF1, 0x00 ×14} with `wr_valid` gaps of 0–3 cycles → exactly 16 handshakes, return to IDLE, `cpu_data` = 0xB5 at `cpu_addr` 0 and 0xF1 at `cpu_addr` 1.
- **Bounded run:** with the above program, `run_start` and `run_limit` = 3 → `cpu_n_reset` high for exactly 3 cycles, `done` = 1, `led` = 4'h5, held indefinitely.
- **Unlimited run:** `run_limit` = 0, `halt_req` after 50 cycles → `cpu_n_reset` low the next cycle, `done` = 1. Then `run_start` → the CPU restarts from ip = 0.
- **Abort and priority:** `load_start` mid-run → `cpu_n_reset` low next cycle, `led` = 0, `wr_ready` = 1. Asserting `load_start` and `run_start` together from IDLE → LOAD wins.
- **Reset mid-load:** `n_reset` low after 7 bytes → IDLE, memory all 0x00. A following full load then works starting from `wptr` = 0.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: run-controller states, program memory geometry and opcodes.
// Used by the run controller, the CPU and the testbench.
package td4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } run_state_t;

   localparam int PROG_DEPTH = 16;
   localparam int INSN_W     = 8;
   localparam int ADDR_W     = 4;

   // Upper nibble of an instruction; the lower nibble is the immediate.
   localparam logic [3:0] OP_ADD_A  = 4'h0;
   localparam logic [3:0] OP_MOV_AB = 4'h1;
   localparam logic [3:0] OP_IN_A   = 4'h2;
   localparam logic [3:0] OP_MOV_A  = 4'h3;
   localparam logic [3:0] OP_MOV_BA = 4'h4;
   localparam logic [3:0] OP_ADD_B  = 4'h5;
   localparam logic [3:0] OP_IN_B   = 4'h6;
   localparam logic [3:0] OP_MOV_B  = 4'h7;
   localparam logic [3:0] OP_OUT_B  = 4'h9;
   localparam logic [3:0] OP_OUT    = 4'hB;
   localparam logic [3:0] OP_JNC    = 4'hE;
   localparam logic [3:0] OP_JMP    = 4'hF;

   function automatic logic [INSN_W-1:0] td4_insn(input logic [3:0] op, input logic [3:0] imm);
      return {op, imm};
   endfunction

endpackage

// File: rtl/td4_prog_mem.sv
// 16x8 program register file: synchronous write, asynchronous read, cleared by reset.
// Write lands on the accepting edge; read is same-cycle combinational.
module td4_prog_mem
   import td4_pkg::*;
(
   input  logic              clk,
   input  logic              n_reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [INSN_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [INSN_W-1:0] rd_data
);

   logic [PROG_DEPTH-1:0][INSN_W-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: loads a 16-byte program (valid/ready, always ready in LOAD), then runs the CPU
// for run_limit cycles (0 = until halt_req); led freezes one cycle after HALT entry.
module td4_run_ctrl
   import td4_pkg::*;
#(
   parameter int LIMIT_W = 16
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic               load_start,
   input  logic               run_start,
   input  logic               halt_req,
   input  logic [LIMIT_W-1:0] run_limit,
   input  logic               wr_valid,
   input  logic [7:0]         wr_data,
   output logic               wr_ready,
   output logic               cpu_n_reset,
   input  logic [3:0]         cpu_addr,
   output logic [7:0]         cpu_data,
   input  logic [3:0]         cpu_led,
   output logic [3:0]         led,
   output logic               busy,
   output logic               done
);

   run_state_t         state_q, state_d;
   logic [ADDR_W-1:0]  wptr_q, wptr_d;
   logic [LIMIT_W-1:0] cnt_q, cnt_d;
   logic [LIMIT_W-1:0] limit_q, limit_d;
   logic [3:0]         led_q, led_d;
   logic               was_run_q, was_run_d;
   logic               wr_fire;
   logic               limit_hit;

   assign wr_fire   = (state_q == ST_LOAD) && wr_valid;
   assign limit_hit = (limit_q != '0) && (cnt_q == limit_q - 1'b1);

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      cnt_d     = cnt_q;
      limit_d   = limit_q;
      was_run_d = (state_q == ST_RUN);
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (load_start) begin
               state_d = ST_LOAD;
               wptr_d  = '0;
            end else if (run_start) begin
               state_d = ST_RUN;
               limit_d = run_limit;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            if (load_start) begin
               wptr_d = '0;
            end else if (wr_valid) begin
               if (wptr_q == ADDR_W'(PROG_DEPTH - 1)) begin
                  state_d = ST_IDLE;
                  wptr_d  = '0;
               end else begin
                  wptr_d = wptr_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (load_start) begin
               state_d = ST_LOAD;
               wptr_d  = '0;
            end else if (halt_req || limit_hit) begin
               state_d = ST_HALT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A stale capture in the first LOAD cycle after an abort would undo the clear.
   always_comb begin
      led_d = led_q;
      if (state_d == ST_LOAD && state_q != ST_LOAD) begin
         led_d = '0;
      end else if (was_run_q && state_q != ST_LOAD) begin
         led_d = cpu_led;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q   <= ST_IDLE;
         wptr_q    <= '0;
         cnt_q     <= '0;
         limit_q   <= '0;
         led_q     <= '0;
         was_run_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         cnt_q     <= cnt_d;
         limit_q   <= limit_d;
         led_q     <= led_d;
         was_run_q <= was_run_d;
      end
   end

   td4_prog_mem u_mem (
      .clk     (clk),
      .n_reset (n_reset),
      .wr_en   (wr_fire),
      .wr_addr (wptr_q),
      .wr_data (wr_data),
      .rd_addr (cpu_addr),
      .rd_data (cpu_data)
   );

   assign wr_ready    = (state_q == ST_LOAD);
   assign cpu_n_reset = (state_q == ST_RUN);
   assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign done        = (state_q == ST_HALT);
   assign led         = led_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl with a small TD4 CPU model (OUT imm, JMP, others step ip).
module tb_td4_run_ctrl;
   import td4_pkg::*;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        load_start = 1'b0;
   logic        run_start = 1'b0;
   logic        halt_req = 1'b0;
   logic [15:0] run_limit = '0;
   logic        wr_valid = 1'b0;
   logic [7:0]  wr_data = '0;
   logic        wr_ready;
   logic        cpu_n_reset;
   logic [3:0]  cpu_addr;
   logic [7:0]  cpu_data;
   logic [3:0]  cpu_led;
   logic [3:0]  led;
   logic        busy;
   logic        done;

   logic [3:0]  ip = '0;
   logic [3:0]  out_r = '0;
   logic        peek_en = 1'b0;
   logic [3:0]  peek_addr = '0;

   logic [7:0]  prog [16];
   logic [7:0]  exp_q [$];
   logic [3:0]  led_exp_q [$];
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   td4_run_ctrl #(.LIMIT_W(16)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .load_start  (load_start),
      .run_start   (run_start),
      .halt_req    (halt_req),
      .run_limit   (run_limit),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .cpu_n_reset (cpu_n_reset),
      .cpu_addr    (cpu_addr),
      .cpu_data    (cpu_data),
      .cpu_led     (cpu_led),
      .led         (led),
      .busy        (busy),
      .done        (done)
   );

   assign cpu_addr = peek_en ? peek_addr : ip;
   assign cpu_led  = out_r;

   always @(posedge clk) begin
      if (!cpu_n_reset) begin
         ip    <= '0;
         out_r <= '0;
      end else begin
         case (cpu_data[7:4])
            OP_OUT: begin
               out_r <= cpu_data[3:0];
               ip    <= ip + 1'b1;
            end
            OP_JMP:  ip <= cpu_data[3:0];
            default: ip <= ip + 1'b1;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_zeros();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
   endtask

   task automatic check_mem(input string tag);
      logic [31:0] e;
      peek_en = 1'b1;
      for (int a = 0; a < 16; a++) begin
         peek_addr = 4'(a);
         #1;
         e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
         chk($sformatf("%s[%0d]", tag, a), 32'(cpu_data), e);
      end
      peek_en = 1'b0;
      tick();
   endtask

   task automatic load_bytes(input int n, input bit sb);
      int hs;
      int guard;
      logic acc;
      hs = 0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("wr_ready_after_load_start", 32'(wr_ready), 1);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         wr_valid = 1'b1;
         wr_data  = prog[i];
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 100) begin
            acc = wr_ready;
            tick();
            guard++;
         end
         if (acc) begin
            hs++;
            if (sb) exp_q.push_back(prog[i]);
         end
         wr_valid = 1'b0;
      end
      chk("handshakes", hs, n);
   endtask

   task automatic run_bounded(input int lim, input logic [3:0] exp_led);
      int hi;
      int guard;
      logic [3:0] e;
      led_exp_q.push_back(exp_led);
      run_limit = 16'(lim);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      hi = 0;
      guard = 0;
      while (cpu_n_reset && guard < 2000) begin
         hi++;
         guard++;
         tick();
      end
      chk("run_cycles", hi, lim);
      chk("done_at_halt", 32'(done), 1);
      chk("busy_at_halt", 32'(busy), 0);
      tick();
      e = led_exp_q.pop_front();
      chk("led_final", 32'(led), 32'(e));
      tick(20);
      chk("led_hold", 32'(led), 32'(e));
      chk("done_hold", 32'(done), 1);
   endtask

   initial begin
      int hi;
      // Reset state and cleared memory.
      tick(3);
      n_reset = 1'b1;
      tick();
      chk("rst_cpu_n_reset", 32'(cpu_n_reset), 0);
      chk("rst_led", 32'(led), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      push_zeros();
      check_mem("rst_mem");

      // Load with stalls: OUT 5; JMP 1; zeros.
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
      prog[0] = td4_insn(OP_OUT, 4'h5);
      prog[1] = td4_insn(OP_JMP, 4'h1);
      load_bytes(16, 1'b1);
      chk("load_idle_busy", 32'(busy), 0);
      chk("load_idle_wr_ready", 32'(wr_ready), 0);
      check_mem("load1_mem");

      // Bounded run; halt_req in HALT is ignored.
      run_bounded(3, 4'h5);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halt_ignored_in_halt", 32'(done), 1);

      // Unlimited run stopped by halt_req.
      led_exp_q.push_back(4'h5);
      run_limit = '0;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         if (cpu_n_reset) hi++;
         tick();
      end
      chk("unlim_high_cycles", hi, 50);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("unlim_halt_n_reset", 32'(cpu_n_reset), 0);
      chk("unlim_halt_done", 32'(done), 1);
      tick();
      chk("unlim_led", 32'(led), 32'(led_exp_q.pop_front()));

      // Restart from HALT begins at ip 0.
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      chk("restart_ip0", 32'(cpu_addr), 0);
      tick();
      chk("restart_ip1", 32'(cpu_addr), 1);

      // Abort a run with load_start.
      tick(5);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("abort_n_reset", 32'(cpu_n_reset), 0);
      chk("abort_wr_ready", 32'(wr_ready), 1);
      chk("abort_busy", 32'(busy), 1);
      tick(2);
      chk("abort_led", 32'(led), 0);
      load_bytes(16, 1'b1);
      check_mem("reload_mem");

      // load_start beats run_start; run_start ignored in LOAD.
      load_start = 1'b1;
      run_start  = 1'b1;
      run_limit  = 16'd5;
      tick();
      load_start = 1'b0;
      run_start  = 1'b0;
      chk("prio_wr_ready", 32'(wr_ready), 1);
      chk("prio_n_reset", 32'(cpu_n_reset), 0);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      chk("run_in_load_ignored", 32'(wr_ready), 1);
      chk("run_in_load_n_reset", 32'(cpu_n_reset), 0);

      // Reset after 7 bytes clears memory; full load then restarts at 0.
      for (int i = 0; i < 15; i++) prog[i] = td4_insn(OP_OUT, 4'(i + 1));
      prog[15] = td4_insn(OP_JMP, 4'h0);
      load_bytes(7, 1'b0);
      n_reset = 1'b0;
      tick();
      n_reset = 1'b1;
      chk("midload_busy", 32'(busy), 0);
      chk("midload_wr_ready", 32'(wr_ready), 0);
      push_zeros();
      check_mem("midload_mem");
      load_bytes(16, 1'b1);
      check_mem("load2_mem");
      run_bounded(4, 4'h4);
      run_bounded(1, 4'h1);

      // halt_req on the same cycle as limit expiry.
      run_limit = 16'd2;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("coinc_done", 32'(done), 1);
      chk("coinc_n_reset", 32'(cpu_n_reset), 0);
      tick();
      chk("coinc_led", 32'(led), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
